// File: rtl/draw_sprite_anim.sv
// Animated sprite overlay for the VGA draw chain; drives an external
// sprite ROM at {frame, y, x} and muxes its pixels into the bus.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 36
`endif

module draw_sprite_anim #(
   parameter int SPRITE_W    = 48,
   parameter int SPRITE_H    = 64,
   parameter int X_BITS      = 6,
   parameter int Y_BITS      = 6,
   parameter int FRAME_BITS  = 2,
   parameter int N_FRAMES    = 4,
   parameter int FRAME_TICKS = 8,
   parameter int SCALE_LOG2  = 0,
   parameter int ROM_LATENCY = 1,
   parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
   input  logic clk,
   input  logic rst,
   input  logic module_en,
   input  logic mirror_x,
   input  logic mirror_y,
   input  logic anim_en,
   input  logic anim_loop,
   input  logic anim_restart,
   input  logic [9:0] xpos,
   input  logic [9:0] ypos,
   input  logic [11:0] rgb_pixel,
   input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
   output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
   output logic [FRAME_BITS+Y_BITS+X_BITS-1:0] pixel_addr,
   output logic [FRAME_BITS-1:0] frame_idx,
   output logic anim_done
);

   localparam int BUS_W  = `VGA_BUS_SIZE;
   localparam int TICK_W = $clog2(FRAME_TICKS + 1);
   localparam logic [11:0] SPAN_W = 12'(SPRITE_W << SCALE_LOG2);
   localparam logic [11:0] SPAN_H = 12'(SPRITE_H << SCALE_LOG2);
   localparam logic [X_BITS-1:0] X_MAX = X_BITS'(SPRITE_W - 1);
   localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(SPRITE_H - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);
   localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(N_FRAMES - 1);

   logic vs_prev, vs_tick;
   logic [9:0] xs, ys;
   logic mx_s, my_s, en_s;
   logic [TICK_W-1:0] tick;
   logic [11:0] h12, v12, dx, dy;
   logic [X_BITS-1:0] rel_x;
   logic [Y_BITS-1:0] rel_y;
   logic hit;
   logic [BUS_W:0] pipe [ROM_LATENCY+1];
   logic hit_d;
   logic [BUS_W-1:0] bus_d;

   assign vs_tick = vga_bus_in[24] & ~vs_prev;
   assign h12 = {1'b0, vga_bus_in[23:13]};
   assign v12 = {1'b0, vga_bus_in[35:25]};

   // Shadow copies keep the hit test stable across a whole video frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_prev <= 1'b0;
         xs      <= '0;
         ys      <= '0;
         mx_s    <= 1'b0;
         my_s    <= 1'b0;
         en_s    <= 1'b0;
      end else begin
         vs_prev <= vga_bus_in[24];
         if (vs_tick) begin
            xs   <= xpos;
            ys   <= ypos;
            mx_s <= mirror_x;
            my_s <= mirror_y;
            en_s <= module_en;
         end
      end
   end

   always_comb begin
      dx  = h12 - {2'b00, xs};
      dy  = v12 - {2'b00, ys};
      hit = (h12 >= {2'b00, xs}) && (h12 < {2'b00, xs} + SPAN_W) &&
            (v12 >= {2'b00, ys}) && (v12 < {2'b00, ys} + SPAN_H);
      rel_x = X_BITS'(dx >> SCALE_LOG2);
      rel_y = Y_BITS'(dy >> SCALE_LOG2);
      if (mx_s) rel_x = X_MAX - rel_x;
      if (my_s) rel_y = Y_MAX - rel_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pixel_addr <= '0;
      else if (hit) pixel_addr <= {frame_idx, rel_y, rel_x};
      else pixel_addr <= {frame_idx, {Y_BITS{1'b0}}, {X_BITS{1'b0}}};
   end

   // Bus and hit flag ride alongside the ROM read so rgb_pixel lines up
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= ROM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {hit, vga_bus_in};
         for (int i = 1; i <= ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign hit_d = pipe[ROM_LATENCY][BUS_W];
   assign bus_d = pipe[ROM_LATENCY][BUS_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vga_bus_out <= '0;
      else if (hit_d && en_s && rgb_pixel != TRANSPARENT)
         vga_bus_out <= {bus_d[BUS_W-1:12], rgb_pixel};
      else vga_bus_out <= bus_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick      <= '0;
         frame_idx <= '0;
         anim_done <= 1'b0;
      end else if (anim_restart) begin
         tick      <= '0;
         frame_idx <= '0;
         anim_done <= 1'b0;
      end else begin
         if (anim_loop) anim_done <= 1'b0;
         if (vs_tick && anim_en) begin
            if (tick == TICK_LAST) begin
               tick <= '0;
               if (frame_idx != FRAME_LAST) frame_idx <= frame_idx + 1'b1;
               else if (anim_loop) frame_idx <= '0;
               else anim_done <= 1'b1;
            end else begin
               tick <= tick + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Directed bench for draw_sprite_anim: default-scale/fast-anim instance
// plus a 2x-scaled instance sharing the same stimulus.
module tb_draw_sprite_anim;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic module_en = 1'b0, mirror_x = 1'b0, mirror_y = 1'b0;
   logic anim_en = 1'b0, anim_loop = 1'b0, anim_restart = 1'b0;
   logic [9:0] xpos = '0, ypos = '0;
   logic [11:0] rgb_pixel = '0;
   logic [35:0] bus_in = '0;
   logic [35:0] out0, out1;
   logic [13:0] addr0, addr1;
   logic [1:0] fr0, fr1;
   logic done0, done1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   draw_sprite_anim #(.FRAME_TICKS(2)) u0 (
      .clk(clk), .rst(rst), .module_en(module_en), .mirror_x(mirror_x),
      .mirror_y(mirror_y), .anim_en(anim_en), .anim_loop(anim_loop),
      .anim_restart(anim_restart), .xpos(xpos), .ypos(ypos),
      .rgb_pixel(rgb_pixel), .vga_bus_in(bus_in), .vga_bus_out(out0),
      .pixel_addr(addr0), .frame_idx(fr0), .anim_done(done0));

   draw_sprite_anim #(.SCALE_LOG2(1)) u1 (
      .clk(clk), .rst(rst), .module_en(module_en), .mirror_x(mirror_x),
      .mirror_y(mirror_y), .anim_en(anim_en), .anim_loop(anim_loop),
      .anim_restart(anim_restart), .xpos(xpos), .ypos(ypos),
      .rgb_pixel(rgb_pixel), .vga_bus_in(bus_in), .vga_bus_out(out1),
      .pixel_addr(addr1), .frame_idx(fr1), .anim_done(done1));

   function automatic logic [35:0] mk(input int v, input int h, input logic [11:0] rgb);
      return {11'(v), 1'b0, 11'(h), 1'b0, rgb};
   endfunction

   function automatic logic [13:0] ad(input int f, input int y, input int x);
      return {2'(f), 6'(y), 6'(x)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic vs_pulse();
      bus_in[24] = 1'b1;
      step();
      bus_in[24] = 1'b0;
      step();
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      chk("rst_bus", 64'(out0), 64'(0));
      chk("rst_addr", 64'(addr0), 64'(0));
      chk("rst_frame", 64'(fr0), 64'(0));
      chk("rst_done", 64'(done0), 64'(0));
      chk("rst_addr_s", 64'(addr1), 64'(0));
      steps(2);
      rst = 1'b0;
      step();

      // basic hit/miss, no mirror
      xpos = 10'd100; ypos = 10'd50; module_en = 1'b1;
      vs_pulse();
      bus_in = mk(50, 100, 12'h123);
      step();
      chk("addr_topleft", 64'(addr0), 64'(ad(0, 0, 0)));
      bus_in = mk(51, 101, 12'h123);
      step();
      chk("addr_1_1", 64'(addr0), 64'(ad(0, 1, 1)));
      bus_in = mk(113, 147, 12'h123);
      step();
      chk("addr_botright", 64'(addr0), 64'(ad(0, 63, 47)));
      bus_in = mk(113, 148, 12'h123);
      step();
      chk("addr_miss_x", 64'(addr0), 64'(0));
      rgb_pixel = 12'h0F0;
      steps(3);
      chk("rgb_miss_pass", 64'(out0), 64'(mk(113, 148, 12'h123)));

      bus_in = mk(51, 101, 12'h123);
      steps(3);
      chk("rgb_hit_draw", 64'(out0), 64'(mk(51, 101, 12'h0F0)));
      rgb_pixel = 12'hFFF;
      steps(3);
      chk("rgb_transparent", 64'(out0), 64'(mk(51, 101, 12'h123)));

      // mirroring, latched at vsync only
      bus_in = mk(0, 0, 12'h000);
      mirror_x = 1'b1; mirror_y = 1'b1;
      step();
      bus_in = mk(50, 100, 12'h000);
      step();
      chk("mirror_not_yet", 64'(addr0), 64'(ad(0, 0, 0)));
      bus_in = mk(0, 0, 12'h000);
      vs_pulse();
      bus_in = mk(50, 100, 12'h000);
      step();
      chk("mirror_xy", 64'(addr0), 64'(ad(0, 63, 47)));
      mirror_x = 1'b0; mirror_y = 1'b0;
      steps(2);
      chk("mirror_held", 64'(addr0), 64'(ad(0, 63, 47)));
      bus_in = mk(0, 0, 12'h000);
      vs_pulse();
      bus_in = mk(50, 100, 12'h000);
      step();
      chk("mirror_off", 64'(addr0), 64'(ad(0, 0, 0)));

      // 2x scale instance
      bus_in = mk(50, 195, 12'h000);
      step();
      chk("scale_x_edge", 64'(addr1), 64'(ad(0, 0, 47)));
      bus_in = mk(50, 196, 12'h000);
      step();
      chk("scale_x_miss", 64'(addr1), 64'(0));
      bus_in = mk(177, 100, 12'h000);
      step();
      chk("scale_y_edge", 64'(addr1), 64'(ad(0, 63, 0)));
      bus_in = mk(178, 100, 12'h000);
      step();
      chk("scale_y_miss", 64'(addr1), 64'(0));

      // module_en=0 passthrough
      module_en = 1'b0;
      rgb_pixel = 12'h0F0;
      bus_in = mk(0, 0, 12'h000);
      vs_pulse();
      bus_in = mk(51, 101, 12'h456);
      steps(3);
      chk("disabled_pass", 64'(out0), 64'(mk(51, 101, 12'h456)));

      // animation
      bus_in = mk(0, 0, 12'h000);
      anim_restart = 1'b1;
      step();
      anim_restart = 1'b0;
      anim_en = 1'b1; anim_loop = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         vs_pulse();
         chk($sformatf("loop_frame_%0d", k), 64'(fr0), 64'((k / 2) % 4));
      end
      anim_loop = 1'b0;
      steps(6 - 6);
      for (int k = 0; k < 6; k++) vs_pulse();
      chk("hold_reach_f", 64'(fr0), 64'(3));
      chk("hold_reach_d", 64'(done0), 64'(0));
      vs_pulse();
      vs_pulse();
      chk("hold_f", 64'(fr0), 64'(3));
      chk("hold_done", 64'(done0), 64'(1));
      vs_pulse();
      vs_pulse();
      chk("hold_still_f", 64'(fr0), 64'(3));
      chk("hold_still_d", 64'(done0), 64'(1));
      anim_loop = 1'b1;
      step();
      chk("done_clear_loop", 64'(done0), 64'(0));
      chk("done_clear_f", 64'(fr0), 64'(3));

      bus_in[24] = 1'b1;
      anim_restart = 1'b1;
      step();
      anim_restart = 1'b0;
      bus_in[24] = 1'b0;
      step();
      chk("restart_frame", 64'(fr0), 64'(0));
      vs_pulse();
      chk("restart_tick0_a", 64'(fr0), 64'(0));
      vs_pulse();
      chk("restart_tick0_b", 64'(fr0), 64'(1));
      anim_en = 1'b0;

      // async reset mid-sprite, then latency after release
      module_en = 1'b1;
      vs_pulse();
      bus_in = mk(60, 110, 12'h321);
      steps(4);
      #2 rst = 1'b1;
      #1;
      chk("arst_bus", 64'(out0), 64'(0));
      chk("arst_addr", 64'(addr0), 64'(0));
      chk("arst_frame", 64'(fr0), 64'(0));
      step();
      #2 rst = 1'b0;
      bus_in = mk(7, 9, 12'hABC);
      step();
      bus_in = mk(8, 10, 12'hDEF);
      step();
      chk("lat_lead", 64'(out0), 64'(0));
      step();
      chk("lat_first", 64'(out0), 64'(mk(7, 9, 12'hABC)));
      step();
      chk("lat_second", 64'(out0), 64'(mk(8, 10, 12'hDEF)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
